// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: opcodes, EXE commands, FSM states
// and the opcode-to-control decode table.
package id_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_AND = 4'd3;
    localparam logic [3:0] CMD_OR  = 4'd4;
    localparam logic [3:0] CMD_NOR = 4'd5;
    localparam logic [3:0] CMD_XOR = 4'd6;
    localparam logic [3:0] CMD_SLA = 4'd7;
    localparam logic [3:0] CMD_SLL = 4'd8;
    localparam logic [3:0] CMD_SRA = 4'd9;
    localparam logic [3:0] CMD_SRL = 4'd10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZ    = 2'd1,
        ST_SQUASH = 2'd2
    } id_state_e;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       imm;
        logic       use_src2;
    } dec_t;

    // Branches and unknown opcodes fall through to an all-zero NOP bundle.
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        logic rtype;
        d = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_ST: d.cmd = CMD_ADD;
            OP_SUB, OP_SUBI:               d.cmd = CMD_SUB;
            OP_AND:                        d.cmd = CMD_AND;
            OP_OR:                         d.cmd = CMD_OR;
            OP_NOR:                        d.cmd = CMD_NOR;
            OP_XOR:                        d.cmd = CMD_XOR;
            OP_SLA:                        d.cmd = CMD_SLA;
            OP_SLL:                        d.cmd = CMD_SLL;
            OP_SRA:                        d.cmd = CMD_SRA;
            OP_SRL:                        d.cmd = CMD_SRL;
            default:                       d.cmd = CMD_NOP;
        endcase
        rtype = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
                           OP_SLA, OP_SLL, OP_SRA, OP_SRL};
        d.use_src2 = rtype || (op == OP_ST);
        d.imm      = op inside {OP_ADDI, OP_SUBI, OP_LD, OP_ST};
        d.wb       = rtype || (op inside {OP_ADDI, OP_SUBI, OP_LD});
        d.mem_r    = (op == OP_LD);
        d.mem_w    = (op == OP_ST);
        return d;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational RAW detect against the EXE and MEM destinations; with ID_FWD_EN
// only a load in EXE can stall. Register 0 never hazards.
module id_hazard_unit
#(
    parameter int RADDR_W = 5
)
(
    input  logic [RADDR_W-1:0] src1,
    input  logic [RADDR_W-1:0] src2,
    input  logic               use_src2,
    input  logic               check,
    input  logic [RADDR_W-1:0] exe_dest,
    input  logic               exe_wb_en,
    input  logic               exe_mem_r,
    input  logic [RADDR_W-1:0] mem_dest,
    input  logic               mem_wb_en,
    output logic               hazard
);

    logic exe_hit_en;
    logic mem_hit_en;

`ifdef ID_FWD_EN
    assign exe_hit_en = exe_wb_en && exe_mem_r;
    assign mem_hit_en = 1'b0;
    logic unused_nofwd;
    assign unused_nofwd = &{1'b0, mem_dest, mem_wb_en};
`else
    assign exe_hit_en = exe_wb_en;
    assign mem_hit_en = mem_wb_en;
    logic unused_fwd;
    assign unused_fwd = &{1'b0, exe_mem_r};
`endif

    function automatic logic hit(input logic [RADDR_W-1:0] src,
                                 input logic [RADDR_W-1:0] dst,
                                 input logic               en);
        return en && (src != '0) && (src == dst);
    endfunction

    logic src1_haz;
    logic src2_haz;

    assign src1_haz = hit(src1, exe_dest, exe_hit_en) || hit(src1, mem_dest, mem_hit_en);
    assign src2_haz = use_src2 &&
                      (hit(src2, exe_dest, exe_hit_en) || hit(src2, mem_dest, mem_hit_en));
    assign hazard   = check && (src1_haz || src2_haz);

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage + ID/EXE register (ID_FWD_EN enables write-back bypass / load-use-only stalls).
// Latency: 1 cycle ID->EXE. Backpressure: bundle held while exe_valid && !exe_ready; id_ready drops.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int CMD_W     = 4,
    parameter int BR_SQUASH = 1,
    parameter int CNT_W     = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        instruction,
    input  logic [DATA_W-1:0]  pc_in,
    output logic               id_ready,
    output logic [RADDR_W-1:0] src1,
    output logic [RADDR_W-1:0] src2,
    input  logic [DATA_W-1:0]  reg1,
    input  logic [DATA_W-1:0]  reg2,
    input  logic [RADDR_W-1:0] exe_dest,
    input  logic               exe_wb_en,
    input  logic               exe_mem_r,
    input  logic [RADDR_W-1:0] mem_dest,
    input  logic               mem_wb_en,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]  wb_value,
    input  logic               exe_ready,
    output logic               exe_valid,
    output logic [RADDR_W-1:0] dest,
    output logic [DATA_W-1:0]  reg2_o,
    output logic [DATA_W-1:0]  val1,
    output logic [DATA_W-1:0]  val2,
    output logic [CMD_W-1:0]   exe_cmd,
    output logic               mem_r_en,
    output logic               mem_w_en,
    output logic               wb_en_o,
    output logic               br_taken,
    output logic [DATA_W-1:0]  br_addr,
    output logic               if_flush,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic       SQ_EN   = (BR_SQUASH > 0);
    localparam logic [1:0] SQ_LOAD = 2'(BR_SQUASH);

    id_state_e   state, state_nxt;
    logic [1:0]  squash_cnt, squash_nxt;

    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op1, op2;
    dec_t              dec;
    logic              advance, hazard, in_squash, accept, issue, br_cond;

    assign opcode  = instruction[31:26];
    assign imm     = instruction[15:0];
    assign src1    = RADDR_W'(instruction[20:16]);
    assign src2    = RADDR_W'(instruction[15:11]);
    assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};
    assign dec     = decode(opcode);

`ifdef ID_FWD_EN
    assign op1 = (wb_en && (wb_dest == src1) && (src1 != '0)) ? wb_value : reg1;
    assign op2 = (wb_en && (wb_dest == src2) && (src2 != '0)) ? wb_value : reg2;
`else
    assign op1 = reg1;
    assign op2 = reg2;
    logic unused_bypass;
    assign unused_bypass = &{1'b0, wb_en, wb_dest, wb_value};
`endif

    // Squashed slots are dropped unchecked, so the hazard unit is gated off there.
    id_hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
        .src1      (src1),
        .src2      (src2),
        .use_src2  (dec.use_src2),
        .check     (id_valid && !in_squash),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .exe_mem_r (exe_mem_r),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .hazard    (hazard)
    );

    assign advance   = !exe_valid || exe_ready;
    assign in_squash = (state == ST_SQUASH);
    assign id_ready  = in_squash ? 1'b1 : (advance && !hazard);
    assign accept    = id_valid && id_ready;
    assign issue     = accept && !in_squash;

    always_comb begin
        br_cond = 1'b0;
        case (opcode)
            OP_BEZ:  br_cond = (op1 == '0);
            OP_BNE:  br_cond = (op1 != op2);
            OP_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = issue && br_cond;
    assign if_flush = br_taken;
    assign br_addr  = pc_in + imm_ext;

    always_comb begin
        state_nxt  = state;
        squash_nxt = squash_cnt;
        case (state)
            ST_RUN, ST_HAZ: begin
                if (hazard) begin
                    state_nxt = ST_HAZ;
                end else if (br_taken && SQ_EN) begin
                    state_nxt  = ST_SQUASH;
                    squash_nxt = SQ_LOAD;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_SQUASH: begin
                if (id_valid) begin
                    if (squash_cnt <= 2'd1) begin
                        state_nxt  = ST_RUN;
                        squash_nxt = 2'd0;
                    end else begin
                        squash_nxt = squash_cnt - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt  = ST_RUN;
                squash_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            squash_cnt <= 2'd0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            squash_cnt <= squash_nxt;
            if ((state == ST_HAZ) && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Bubbles only clear exe_valid; stale payload is harmless behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid <= 1'b0;
            dest      <= '0;
            reg2_o    <= '0;
            val1      <= '0;
            val2      <= '0;
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en_o   <= 1'b0;
        end else if (advance) begin
            exe_valid <= issue;
            if (issue) begin
                dest     <= RADDR_W'(instruction[25:21]);
                reg2_o   <= op2;
                val1     <= op1;
                val2     <= dec.imm ? imm_ext : op2;
                exe_cmd  <= CMD_W'(dec.cmd);
                mem_r_en <= dec.mem_r;
                mem_w_en <= dec.mem_w;
                wb_en_o  <= dec.wb;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (default build): issued bundles are
// scoreboarded, combinational and boundary behaviour is checked in place.
module tb_id_stage_pipe;
    import id_pkg::*;

    logic        clk, rst, id_valid, id_ready;
    logic [31:0] instruction, pc_in, reg1, reg2, wb_value;
    logic [4:0]  src1, src2, exe_dest, mem_dest, wb_dest, dest;
    logic        exe_wb_en, exe_mem_r, mem_wb_en, wb_en, exe_ready, exe_valid;
    logic [31:0] reg2_o, val1, val2, br_addr;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en_o, br_taken, if_flush;
    logic [15:0] stall_cnt;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction),
        .pc_in(pc_in), .id_ready(id_ready), .src1(src1), .src2(src2),
        .reg1(reg1), .reg2(reg2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_ready(exe_ready), .exe_valid(exe_valid), .dest(dest),
        .reg2_o(reg2_o), .val1(val1), .val2(val2), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_o(wb_en_o),
        .br_taken(br_taken), .br_addr(br_addr), .if_flush(if_flush),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] reg2;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [3:0]  cmd;
        logic        mr, mw, wb;
    } bundle_t;

    bundle_t q[$];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [4:0] d, input logic [31:0] r2, v1, v2,
                                   input logic [3:0] c, input logic mr, mw, wb);
        bundle_t b;
        b.dest = d; b.reg2 = r2; b.val1 = v1; b.val2 = v2;
        b.cmd = c; b.mr = mr; b.mw = mw; b.wb = wb;
        return b;
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] d, s1, s2);
        return {op, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] d, s1,
                                       input logic [15:0] im);
        return {op, d, s1, im};
    endfunction

    // A transfer happens at the next posedge if both are high at the negedge.
    always @(negedge clk) begin
        if (rst && exe_valid && exe_ready) begin
            if (q.size() == 0) begin
                check("unexpected_issue", exe_valid, 0);
            end else begin
                bundle_t e;
                e = q.pop_front();
                check("bundle_dest", dest, e.dest);
                check("bundle_reg2", reg2_o, e.reg2);
                check("bundle_val1", val1, e.val1);
                check("bundle_val2", val2, e.val2);
                check("bundle_cmd", exe_cmd, e.cmd);
                check("bundle_ctl", {mem_r_en, mem_w_en, wb_en_o}, {e.mr, e.mw, e.wb});
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, r1, r2);
        instruction = ins; pc_in = pc; reg1 = r1; reg2 = r2; id_valid = 1'b1;
        #1;
    endtask

    task automatic accept(input bundle_t e, input string tag);
        int n = 0;
        while (!id_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, id_ready, 1);
        if (id_ready) q.push_back(e);
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b0; id_valid = 1'b0; instruction = '0; pc_in = '0; reg1 = '0; reg2 = '0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0; exe_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_exe_valid", exe_valid, 0);
        check("rst_bundle", {dest, reg2_o, val1, val2, exe_cmd}, 0);
        check("rst_ctl", {mem_r_en, mem_w_en, wb_en_o}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", id_ready, 1);

        // basic decode
        drive(rr(OP_ADD, 5'd3, 5'd1, 5'd2), 32'd1, 32'd5, 32'd7);
        check("add_src1", src1, 1);
        check("add_src2", src2, 2);
        accept(mk(5'd3, 32'd7, 32'd5, 32'd7, CMD_ADD, 0, 0, 1), "add");
        check("add_issue_valid", exe_valid, 1);
        drive(ri(OP_ADDI, 5'd5, 5'd1, 16'hFFFD), 32'd2, 32'd5, 32'd9);
        accept(mk(5'd5, 32'd9, 32'd5, 32'hFFFF_FFFD, CMD_ADD, 0, 0, 1), "addi");
        drive(ri(OP_LD, 5'd6, 5'd1, 16'h0004), 32'd3, 32'd100, 32'd0);
        accept(mk(5'd6, 32'd0, 32'd100, 32'd4, CMD_ADD, 1, 0, 1), "ld");
        drive(ri(OP_ST, 5'd2, 5'd1, 16'h1008), 32'd4, 32'd100, 32'd55);
        accept(mk(5'd2, 32'd55, 32'd100, 32'h1008, CMD_ADD, 0, 1, 0), "st");
        drive(rr(OP_XOR, 5'd7, 5'd1, 5'd2), 32'd5, 32'd3, 32'd6);
        accept(mk(5'd7, 32'd6, 32'd3, 32'd6, CMD_XOR, 0, 0, 1), "xor");
        drive(ri(6'd63, 5'd9, 5'd1, 16'h0000), 32'd6, 32'd11, 32'd0);
        accept(mk(5'd9, 32'd0, 32'd11, 32'd0, CMD_NOP, 0, 0, 0), "unknown_op");
        idle(2);
        check("drain_valid", exe_valid, 0);

        // RAW hazard against EXE: bubbles while held, stall_cnt counts HAZ cycles
        exe_dest = 5'd3; exe_wb_en = 1'b1;
        drive(rr(OP_ADD, 5'd4, 5'd3, 5'd1), 32'd7, 32'd20, 32'd5);
        check("haz_ready0", id_ready, 0);
        @(posedge clk); #1;
        check("haz_bubble", exe_valid, 0);
        check("haz_ready1", id_ready, 0);
        check("haz_cnt0", stall_cnt, 0);
        @(posedge clk); #1;
        check("haz_cnt1", stall_cnt, 1);
        check("haz_bubble2", exe_valid, 0);
        @(posedge clk); #1;
        check("haz_cnt2", stall_cnt, 2);
        exe_wb_en = 1'b0;
        #1;
        accept(mk(5'd4, 32'd5, 32'd20, 32'd5, CMD_ADD, 0, 0, 1), "haz_clear");
        check("haz_cnt3", stall_cnt, 3);
        idle(1);
        check("run_cnt_hold", stall_cnt, 3);

        // MEM hazard on src2, src2 ignored for immediates, register 0 never hazards
        mem_dest = 5'd7; mem_wb_en = 1'b1;
        drive(rr(OP_ADD, 5'd8, 5'd1, 5'd7), 32'd8, 32'd1, 32'd2);
        check("mem_haz_src2", id_ready, 0);
        mem_wb_en = 1'b0;
        #1;
        accept(mk(5'd8, 32'd2, 32'd1, 32'd2, CMD_ADD, 0, 0, 1), "mem_clear");
        exe_dest = 5'd3; exe_wb_en = 1'b1;
        drive(ri(OP_ADDI, 5'd10, 5'd1, 16'h1800), 32'd9, 32'd4, 32'd8);
        check("imm_no_src2_haz", id_ready, 1);
        accept(mk(5'd10, 32'd8, 32'd4, 32'h1800, CMD_ADD, 0, 0, 1), "addi_nohaz");
        exe_dest = 5'd0;
        drive(rr(OP_ADD, 5'd9, 5'd0, 5'd0), 32'd10, 32'd0, 32'd0);
        check("r0_no_haz", id_ready, 1);
        accept(mk(5'd9, 32'd0, 32'd0, 32'd0, CMD_ADD, 0, 0, 1), "r0");
        exe_wb_en = 1'b0;

        // branches and squash
        drive(ri(OP_BNE, 5'd0, 5'd1, 16'hFFFC), 32'd10, 32'd1, 32'd2);
        check("bne_taken", br_taken, 1);
        check("bne_flush", if_flush, 1);
        check("bne_addr", br_addr, 6);
        accept(mk(5'd0, 32'd2, 32'd1, 32'd2, CMD_NOP, 0, 0, 0), "bne");
        drive(ri(OP_JMP, 5'd0, 5'd0, 16'h0005), 32'd20, 32'd0, 32'd0);
        check("squash_ready", id_ready, 1);
        check("squash_no_br", br_taken, 0);
        check("squash_no_flush", if_flush, 0);
        @(posedge clk); #1;
        id_valid = 1'b0;
        check("squash_no_issue", exe_valid, 0);
        drive(ri(OP_BEZ, 5'd0, 5'd1, 16'h0010), 32'd30, 32'd3, 32'd0);
        check("bez_not_taken", br_taken, 0);
        accept(mk(5'd0, 32'd0, 32'd3, 32'd0, CMD_NOP, 0, 0, 0), "bez_nt");
        drive(ri(OP_BEZ, 5'd0, 5'd1, 16'h8000), 32'h10, 32'd0, 32'd0);
        check("bez_taken", br_taken, 1);
        check("bez_addr_neg", br_addr, 32'hFFFF_8010);
        accept(mk(5'd0, 32'd0, 32'd0, 32'd0, CMD_NOP, 0, 0, 0), "bez_t");
        drive(rr(OP_ADD, 5'd14, 5'd1, 5'd2), 32'd40, 32'd1, 32'd2);
        check("squash2_ready", id_ready, 1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        drive(ri(OP_JMP, 5'd0, 5'd0, 16'h0002), 32'hFFFF_FFFF, 32'd0, 32'd0);
        check("jmp_taken", br_taken, 1);
        check("jmp_addr_wrap", br_addr, 1);
        accept(mk(5'd0, 32'd0, 32'd0, 32'd0, CMD_NOP, 0, 0, 0), "jmp");
        exe_dest = 5'd3; exe_wb_en = 1'b1;
        drive(rr(OP_ADD, 5'd14, 5'd3, 5'd0), 32'd50, 32'd0, 32'd0);
        check("squash_ignores_haz", id_ready, 1);
        @(posedge clk); #1;
        exe_wb_en = 1'b0;
        idle(2);

        // backpressure: bundle held bit-stable, nothing lost
        exe_ready = 1'b0;
        drive(rr(OP_SUB, 5'd11, 5'd1, 5'd2), 32'd60, 32'd40, 32'd15);
        accept(mk(5'd11, 32'd15, 32'd40, 32'd15, CMD_SUB, 0, 0, 1), "sub");
        drive(rr(OP_OR, 5'd12, 5'd1, 5'd2), 32'd61, 32'd8, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", id_ready, 0);
            check("bp_valid", exe_valid, 1);
            check("bp_hold", {dest, val1, val2, exe_cmd}, {5'd11, 32'd40, 32'd15, CMD_SUB});
            @(posedge clk); #1;
        end
        exe_ready = 1'b1;
        #1;
        accept(mk(5'd12, 32'd1, 32'd8, 32'd1, CMD_OR, 0, 0, 1), "or");
        idle(2);

        // reset in the middle of a hazard
        exe_dest = 5'd4; exe_wb_en = 1'b1;
        drive(rr(OP_ADD, 5'd13, 5'd4, 5'd0), 32'd70, 32'd77, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_cnt", stall_cnt, 4);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", exe_valid, 0);
        check("mid_rst_bundle", {dest, reg2_o, val1, val2, exe_cmd}, 0);
        check("mid_rst_ctl", {mem_r_en, mem_w_en, wb_en_o}, 0);
        check("mid_rst_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_run", stall_cnt, 0);
        @(posedge clk); #1;
        check("post_rst_haz", stall_cnt, 1);
        exe_wb_en = 1'b0;
        #1;
        accept(mk(5'd13, 32'd0, 32'd77, 32'd0, CMD_ADD, 0, 0, 1), "post_rst");
        idle(3);
        check("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
